morse_char_tx: RTL and testbench

- ASCII-to-Morse transmitter; the transmit end of the Morse symbol link consumed by the Morse-to-character receiver.
- Accepts one ASCII letter per valid/ready handshake and looks up its Morse code.
- Emits a timed on/off key signal for a buzzer or LED.
- Emits a parallel symbol stream (1 = dot, 2 = dash, 0 = end of character) that drives the receiver's symbol input directly for loopback.

---
 rtl/morse_pkg.sv | 36 +++
 rtl/morse_encode_rom.sv | 49 ++++
 rtl/morse_char_tx.sv | 120 ++++++++++++
 tb/tb_morse_char_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: shared types and timing constants for the Morse character transmitter.
// The MORSE_WORD_GAP_EN macro enables space as a word-gap character in morse_encode_rom.
package morse_pkg;

   typedef enum logic [1:0] {
      SYM_END  = 2'd0,
      SYM_DOT  = 2'd1,
      SYM_DASH = 2'd2
   } sym_t;

   typedef enum logic [2:0] {
      IDLE,
      MARK,
      SPACE,
      CHARGAP,
      WORDGAP
   } tx_state_t;

   localparam int DOT_UNITS      = 1;
   localparam int DASH_UNITS     = 3;
   localparam int ELEM_GAP_UNITS = 1;
   localparam int CHAR_GAP_UNITS = 3;
   localparam int WORD_GAP_UNITS = 7;

   // code is right-aligned: the first element is code[len-1], 1 = dash
   typedef struct packed {
      logic       supported;
      logic [2:0] len;
      logic [3:0] code;
   } morse_code_t;

   function automatic morse_code_t mc(input logic [2:0] len, input logic [3:0] code);
      return {1'b1, len, code};
   endfunction

endpackage

// File: rtl/morse_encode_rom.sv
// morse_encode_rom: combinational case-folded ASCII letter to Morse code lookup.
// With MORSE_WORD_GAP_EN defined, space maps to a supported zero-length code (word gap).
module morse_encode_rom
   import morse_pkg::*;
(
   input  logic [7:0]  char_in,
   output morse_code_t code
);

   logic [7:0] folded;

   always_comb begin
      folded = (char_in >= 8'h61 && char_in <= 8'h7A) ? char_in - 8'h20 : char_in;
      code = '0;
      case (folded)
         8'h41: code = mc(3'd2, 4'b0001);
         8'h42: code = mc(3'd4, 4'b1000);
         8'h43: code = mc(3'd4, 4'b1010);
         8'h44: code = mc(3'd3, 4'b0100);
         8'h45: code = mc(3'd1, 4'b0000);
         8'h46: code = mc(3'd4, 4'b0010);
         8'h47: code = mc(3'd3, 4'b0110);
         8'h48: code = mc(3'd4, 4'b0000);
         8'h49: code = mc(3'd2, 4'b0000);
         8'h4A: code = mc(3'd4, 4'b0111);
         8'h4B: code = mc(3'd3, 4'b0101);
         8'h4C: code = mc(3'd4, 4'b0100);
         8'h4D: code = mc(3'd2, 4'b0011);
         8'h4E: code = mc(3'd2, 4'b0010);
         8'h4F: code = mc(3'd3, 4'b0111);
         8'h50: code = mc(3'd4, 4'b0110);
         8'h51: code = mc(3'd4, 4'b1101);
         8'h52: code = mc(3'd3, 4'b0010);
         8'h53: code = mc(3'd3, 4'b0000);
         8'h54: code = mc(3'd1, 4'b0001);
         8'h55: code = mc(3'd3, 4'b0001);
         8'h56: code = mc(3'd4, 4'b0001);
         8'h57: code = mc(3'd3, 4'b0011);
         8'h58: code = mc(3'd4, 4'b1001);
         8'h59: code = mc(3'd4, 4'b1011);
         8'h5A: code = mc(3'd4, 4'b1100);
`ifdef MORSE_WORD_GAP_EN
         8'h20: code = mc(3'd0, 4'b0000);
`endif
         default: code = '0;
      endcase
   end

endmodule

// File: rtl/morse_char_tx.sv
// morse_char_tx: ASCII-to-Morse transmitter producing a timed key signal and a dot/dash/end symbol stream.
// MORSE_WORD_GAP_EN (in morse_encode_rom) adds space as a 7-unit word gap.
module morse_char_tx
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   output logic       key_out,
   output logic       sym_valid,
   output logic [1:0] sym,
   output logic       busy,
   output logic       err
);

   localparam int CW = $clog2(7 * UNIT_CYCLES + 1);
   localparam logic [CW-1:0] DOT_LD  = CW'(DOT_UNITS * UNIT_CYCLES - 1);
   localparam logic [CW-1:0] DASH_LD = CW'(DASH_UNITS * UNIT_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD  = CW'(ELEM_GAP_UNITS * UNIT_CYCLES - 1);
   localparam logic [CW-1:0] CHAR_LD = CW'((CHAR_GAP_UNITS - ELEM_GAP_UNITS) * UNIT_CYCLES - 1);
   localparam logic [CW-1:0] WORD_LD = CW'(WORD_GAP_UNITS * UNIT_CYCLES - 1);

   tx_state_t   state;
   logic [CW-1:0] cnt;
   logic [2:0]  shreg;
   logic [2:0]  len;
   morse_code_t rom;
   logic [3:0]  aligned;
   logic        accept;

   morse_encode_rom u_rom (
      .char_in (char_in),
      .code    (rom)
   );

   // left-align the code so the element being sent next is always at the top
   assign aligned    = rom.code << (3'd4 - rom.len);
   assign accept     = char_valid && char_ready;
   assign char_ready = state == IDLE;
   assign busy       = state != IDLE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         shreg     <= '0;
         len       <= '0;
         key_out   <= 1'b0;
         sym_valid <= 1'b0;
         sym       <= SYM_END;
         err       <= 1'b0;
      end else begin
         sym_valid <= 1'b0;
         err       <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (!rom.supported) begin
                     err <= 1'b1;
                  end else if (rom.len == 3'd0) begin
                     state <= WORDGAP;
                     cnt   <= WORD_LD;
                  end else begin
                     state     <= MARK;
                     cnt       <= aligned[3] ? DASH_LD : DOT_LD;
                     shreg     <= aligned[2:0];
                     len       <= rom.len;
                     key_out   <= 1'b1;
                     sym_valid <= 1'b1;
                     sym       <= aligned[3] ? SYM_DASH : SYM_DOT;
                  end
               end
            end
            MARK: begin
               if (cnt == '0) begin
                  state   <= SPACE;
                  cnt     <= GAP_LD;
                  key_out <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            SPACE: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (len > 3'd1) begin
                  state     <= MARK;
                  cnt       <= shreg[2] ? DASH_LD : DOT_LD;
                  shreg     <= {shreg[1:0], 1'b0};
                  len       <= len - 1'b1;
                  key_out   <= 1'b1;
                  sym_valid <= 1'b1;
                  sym       <= shreg[2] ? SYM_DASH : SYM_DOT;
               end else begin
                  state <= CHARGAP;
                  cnt   <= CHAR_LD;
               end
            end
            CHARGAP, WORDGAP: begin
               // end strobe is registered so it lands on the final gap cycle
               if (cnt == '0) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
                  if (cnt == CW'(1)) begin
                     sym_valid <= 1'b1;
                     sym       <= SYM_END;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_morse_char_tx.sv
// tb_morse_char_tx: table-driven check of morse_char_tx at UNIT_CYCLES = 2.
// Define MORSE_WORD_GAP_EN for both bench and RTL to cover the word-gap row.
module tb_morse_char_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] char_in = 8'h00;
   logic       char_valid = 1'b0;
   logic       char_ready, key_out, sym_valid, busy, err;
   logic [1:0] sym;

   int tests = 0;
   int fails = 0;

   int          busy_c, key_c, err_c, nsym, end_i, rdy_first, ready_c;
   logic [63:0] keyv;
   logic [15:0] syms;

   typedef struct {
      logic [7:0] ch;
      string      morse;
      bit         sup;
      int         busy_n;
      int         key_n;
   } vec_t;

   vec_t vecs[$];

   morse_char_tx #(.UNIT_CYCLES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .key_out    (key_out),
      .sym_valid  (sym_valid),
      .sym        (sym),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // key-on pattern from a dot/dash string, UNIT_CYCLES = 2: dot 2, dash 6, gaps 2
   function automatic logic [63:0] kpat(input string m);
      logic [63:0] p = '0;
      int pos = 0;
      for (int k = 0; k < m.len(); k++) begin
         int n;
         n = (m[k] == 8'h2D) ? 6 : 2;
         for (int j = 0; j < n; j++) p[pos + j] = 1'b1;
         pos += n + 2;
      end
      return p;
   endfunction

   function automatic logic [15:0] spat(input string m);
      logic [15:0] s = '0;
      for (int k = 0; k < m.len(); k++) s[2*k +: 2] = (m[k] == 8'h2D) ? 2'd2 : 2'd1;
      return s;
   endfunction

   task automatic run_char(input logic [7:0] c, input int win);
      busy_c = 0; key_c = 0; err_c = 0; nsym = 0; end_i = 0; rdy_first = 0; ready_c = 0;
      keyv = '0; syms = '0;
      @(negedge clk);
      check("ready_before", {63'd0, char_ready}, 64'd1);
      char_in = c;
      char_valid = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= win; i++) begin
         @(negedge clk);
         if (i == 1) char_valid = 1'b0;
         if (busy) busy_c++;
         if (key_out) begin
            key_c++;
            keyv[i-1] = 1'b1;
         end
         if (err) err_c++;
         if (char_ready) ready_c++;
         if (char_ready && rdy_first == 0) rdy_first = i;
         if (sym_valid) begin
            if (nsym < 8) syms[2*nsym +: 2] = sym;
            nsym++;
            if (sym == 2'd0 && end_i == 0) end_i = i;
         end
      end
   endtask

   initial begin
      vecs.push_back('{8'h45, ".",    1'b1, 8,  2});
      vecs.push_back('{8'h54, "-",    1'b1, 12, 6});
      vecs.push_back('{8'h51, "--.-", 1'b1, 32, 20});
      vecs.push_back('{8'h61, ".-",   1'b1, 16, 8});
      vecs.push_back('{8'h35, "",     1'b0, 0,  0});
      vecs.push_back('{8'h53, "...",  1'b1, 16, 6});
      vecs.push_back('{8'h4F, "---",  1'b1, 28, 18});
      vecs.push_back('{8'h53, "...",  1'b1, 16, 6});
      vecs.push_back('{8'h7A, "--..", 1'b1, 28, 16});
      vecs.push_back('{8'h42, "-...", 1'b1, 24, 12});
      vecs.push_back('{8'h65, ".",    1'b1, 8,  2});
      vecs.push_back('{8'h40, "",     1'b0, 0,  0});
      vecs.push_back('{8'h5B, "",     1'b0, 0,  0});
      vecs.push_back('{8'h7B, "",     1'b0, 0,  0});
`ifdef MORSE_WORD_GAP_EN
      vecs.push_back('{8'h20, "",     1'b1, 14, 0});
`else
      vecs.push_back('{8'h20, "",     1'b0, 0,  0});
`endif

      repeat (2) @(negedge clk);
      check("rst_key", {63'd0, key_out}, 64'd0);
      check("rst_sym_valid", {63'd0, sym_valid}, 64'd0);
      check("rst_sym", {62'd0, sym}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_err", {63'd0, err}, 64'd0);
      check("rst_ready", {63'd0, char_ready}, 64'd1);
      rst_n = 1'b1;

      foreach (vecs[v]) begin
         run_char(vecs[v].ch, 40);
         check($sformatf("busy[%0h]", vecs[v].ch), 64'(busy_c), 64'(vecs[v].busy_n));
         check($sformatf("key_cnt[%0h]", vecs[v].ch), 64'(key_c), 64'(vecs[v].key_n));
         check($sformatf("key_pat[%0h]", vecs[v].ch), keyv, kpat(vecs[v].morse));
         check($sformatf("nsym[%0h]", vecs[v].ch), 64'(nsym), vecs[v].sup ? 64'(vecs[v].morse.len() + 1) : 64'd0);
         check($sformatf("syms[%0h]", vecs[v].ch), {48'd0, syms}, {48'd0, spat(vecs[v].morse)});
         check($sformatf("err[%0h]", vecs[v].ch), 64'(err_c), vecs[v].sup ? 64'd0 : 64'd1);
         check($sformatf("end_at[%0h]", vecs[v].ch), 64'(end_i), vecs[v].sup ? 64'(vecs[v].busy_n) : 64'd0);
         check($sformatf("ready_at[%0h]", vecs[v].ch), 64'(rdy_first), vecs[v].sup ? 64'(vecs[v].busy_n + 1) : 64'd1);
         if (!vecs[v].sup) check($sformatf("ready_held[%0h]", vecs[v].ch), 64'(ready_c), 64'd40);
      end

      // back-to-back E then T with char_valid held
      begin
         logic [63:0] kv = '0;
         logic [63:0] rv = '0;
         logic [15:0] sv = '0;
         int ns = 0;
         @(negedge clk);
         char_in = 8'h45;
         char_valid = 1'b1;
         @(posedge clk);
         for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) char_in = 8'h54;
            if (i >= 10 && busy) char_valid = 1'b0;
            kv[i-1] = key_out;
            if (i <= 20) rv[i-1] = char_ready;
            if (sym_valid) begin
               if (ns < 8) sv[2*ns +: 2] = sym;
               ns++;
            end
         end
         char_valid = 1'b0;
         check("b2b_key", kv, 64'h7E03);
         check("b2b_ready", rv, 64'h100);
         check("b2b_nsym", 64'(ns), 64'd4);
         check("b2b_syms", {48'd0, sv}, 64'h21);
      end

      // reset mid-dash of O
      begin
         int sv_c = 0;
         int k_c = 0;
         int r_c = 0;
         @(negedge clk);
         char_in = 8'h4F;
         char_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         char_valid = 1'b0;
         @(negedge clk);
         @(negedge clk);
         check("mid_dash_key", {63'd0, key_out}, 64'd1);
         rst_n = 1'b0;
         #1;
         check("abort_key", {63'd0, key_out}, 64'd0);
         check("abort_busy", {63'd0, busy}, 64'd0);
         check("abort_sym_valid", {63'd0, sym_valid}, 64'd0);
         check("abort_ready", {63'd0, char_ready}, 64'd1);
         @(negedge clk);
         rst_n = 1'b1;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sym_valid) sv_c++;
            if (key_out) k_c++;
            if (char_ready) r_c++;
         end
         check("post_abort_syms", 64'(sv_c), 64'd0);
         check("post_abort_key", 64'(k_c), 64'd0);
         check("post_abort_ready", 64'(r_c), 64'd40);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
